// File: rtl/decoder.sv
// Registered binary-to-one-hot decoder (optionally inverted), used for write strobes and mux selects.
// Latency 1 clk; no backpressure, and each cycle's en alone gates that cycle's strobe.
module decoder #(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y,
  output logic             valid
);

  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [OUT_W-1:0] one_hot;
  logic [OUT_W-1:0] y_nxt;

  always_comb begin
    one_hot = '0;
    if (en) begin
      one_hot[x] = 1'b1;
    end
    y_nxt = ACTIVE_LOW ? ~one_hot : one_hot;
  end

  // Only y and valid hold state, so the strobes come straight from flops and cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y     <= INACTIVE;
      valid <= 1'b0;
    end else begin
      y     <= y_nxt;
      valid <= en;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: active-high build (dut) and inverted build (dut_n) share one stimulus.
module tb_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [2:0] x   = 3'd0;
  logic [7:0] y, y_n;
  logic       valid, valid_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder #(.IN_W(3), .OUT_W(8), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .valid(valid)
  );

  decoder #(.IN_W(3), .OUT_W(8), .ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y_n), .valid(valid_n)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; x = 3'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (y !== 8'h00 || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: y=%h valid=%b, expected y=00 valid=0", i, y, valid);
      end
      n_checks++;
      if (y_n !== 8'hFF || valid_n !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold_n cycle %0d: y=%h valid=%b, expected y=ff valid=0", i, y_n, valid_n);
      end
    end
    rst = 1'b0;
    #2;
    n_checks++;
    if (y !== 8'h00 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_pre_edge: y=%h valid=%b, expected y=00 valid=0", y, valid);
    end
    step();
    n_checks++;
    if (y !== 8'h20 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_decode: y=%h valid=%b, expected y=20 valid=1", y, valid);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = 3'(i);
      step();
      n_checks++;
      if (y !== exp_tab[i] || valid !== 1'b1 || $countones(y) != 1) begin
        n_fail++;
        $display("FAIL sweep x=%0d: y=%h valid=%b, expected y=%h valid=1", i, y, valid, exp_tab[i]);
      end
    end
  endtask

  task automatic test_enable();
    x = 3'd3; en = 1'b1;
    step();
    n_checks++;
    if (y !== 8'h08 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_on: y=%h valid=%b, expected y=08 valid=1", y, valid);
    end
    en = 1'b0;
    step();
    n_checks++;
    if (y !== 8'h00 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_off: y=%h valid=%b, expected y=00 valid=0", y, valid);
    end
    en = 1'b1;
    step();
    n_checks++;
    if (y !== 8'h08 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_back_on: y=%h valid=%b, expected y=08 valid=1", y, valid);
    end
  endtask

  task automatic test_async_reset();
    x = 3'd6; en = 1'b1;
    step();
    n_checks++;
    if (y !== 8'h40 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: y=%h valid=%b, expected y=40 valid=1", y, valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (y !== 8'h00 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: y=%h valid=%b, expected y=00 valid=0", y, valid);
    end
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (y !== 8'h40 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_recover: y=%h valid=%b, expected y=40 valid=1", y, valid);
    end
  endtask

  task automatic test_stability();
    x = 3'd5; en = 1'b1;
    step();
    x = 3'd2;
    #2 x = 3'd6;
    #1;
    n_checks++;
    if (y !== 8'h20) begin
      n_fail++;
      $display("FAIL stable_mid_x6: y=%h, expected y=20", y);
    end
    #1 x = 3'd2;
    #1;
    n_checks++;
    if (y !== 8'h20) begin
      n_fail++;
      $display("FAIL stable_mid_x2: y=%h, expected y=20", y);
    end
    step();
    n_checks++;
    if (y !== 8'h04 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stable_after_edge: y=%h valid=%b, expected y=04 valid=1", y, valid);
    end
  endtask

  task automatic test_active_low();
    en = 1'b1; x = 3'd0;
    step();
    n_checks++;
    if (y_n !== 8'hFE || valid_n !== 1'b1) begin
      n_fail++;
      $display("FAIL active_low_x0: y=%h valid=%b, expected y=fe valid=1", y_n, valid_n);
    end
    x = 3'd7;
    step();
    n_checks++;
    if (y_n !== 8'h7F || valid_n !== 1'b1) begin
      n_fail++;
      $display("FAIL active_low_x7: y=%h valid=%b, expected y=7f valid=1", y_n, valid_n);
    end
    en = 1'b0;
    step();
    n_checks++;
    if (y_n !== 8'hFF || valid_n !== 1'b0) begin
      n_fail++;
      $display("FAIL active_low_en0: y=%h valid=%b, expected y=ff valid=0", y_n, valid_n);
    end
    en = 1'b1; x = 3'd4;
    step();
    n_checks++;
    if (y_n !== 8'hEF) begin
      n_fail++;
      $display("FAIL active_low_x4: y=%h, expected y=ef", y_n);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (y_n !== 8'hFF || valid_n !== 1'b0) begin
      n_fail++;
      $display("FAIL active_low_reset: y=%h valid=%b, expected y=ff valid=0", y_n, valid_n);
    end
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_enable();
    test_async_reset();
    test_stability();
    test_active_low();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- Registered binary-to-one-hot decoder: 3-bit index x in, 8-bit one-hot vector y out (bit x set, all others clear).
- Used as a select/enable generator, for example for register-bank write strobes or mux selects.
- Single clock domain with an asynchronous active-high reset.
- Output is registered to give clean, glitch-free strobes.

Parameters:
- IN_W, 3, width of index input x.
- OUT_W, 8, width of output y; must equal 2**IN_W.
- ACTIVE_LOW, 0, when 1 the asserted output bit is 0 and all others are 1 (inverted one-hot).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  decode enable; when low, no output bit is asserted.
- x  input  IN_W  binary index to decode.
- y  output  OUT_W  registered one-hot decode of x.
- valid  output  1  registered copy of en; high when y holds a decoded value.

Behaviour:
- Reset:
  - While rst is high, y = all-inactive (0x00 when ACTIVE_LOW=0, 0xFF when ACTIVE_LOW=1) and valid = 0.
  - Reset takes effect immediately, independent of clk.
  - Release is synchronous to the next rising edge. The first decode appears on the first rising edge after rst falls.
- Latency: exactly 1 clock. At each rising edge:
  - if en=1: y <= (1 << x), inverted if ACTIVE_LOW=1.
  - if en=0: y <= all-inactive.
  - valid <= en.
- Exactly one bit is active when valid=1; zero bits are active when valid=0.
- Mapping is fixed for all codes, including extremes:
  - x=0 → y=0x01.
  - x=7 → y=0x80.
  - No wrap-around or out-of-range case exists, because every x code is valid.
- x or en changing between edges has no effect on y until the next rising edge. Output never glitches.
- Back-to-back changes of x on consecutive cycles produce consecutive one-hot values with no idle cycle between them.
- Reset asserted mid-stream clears y and valid at once. The value captured at the edge coincident with reset release is discarded.
- X/Z on x while en=1 is not defined. The bench must not drive it.
- No internal state other than the y and valid registers.

Test Plan:
- Reset: assert rst with en=1, x=5, toggling clk → y=0x00, valid=0 throughout; release rst → next edge y=0x20, valid=1.
- Full sweep: en=1, drive x=0..7 on successive cycles → y = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80, each one cycle after its x; exactly one bit set each cycle.
- Enable gating: x=3, en 1→0→1 on successive edges → y = 0x08, 0x00 (valid=0), 0x08 (valid=1).
- Async reset mid-stream: with y=0x40, raise rst between clock edges → y=0x00 and valid=0 immediately, before the next edge.
- Between-edge stability: change x from 2 to 6 and back to 2 between two edges → y remains at the prior value, then 0x04 after the edge.
- ACTIVE_LOW=1 build: x=0 → y=0xFE; x=7 → y=0x7F; en=0 → y=0xFF; reset → y=0xFF.
